// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared types, defaults and saturation helpers for the sequential divider
package fixed_point_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_FRAC      = 6;
    localparam int DEF_OUT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    // Results are returned 64 bits wide and truncated by the caller to OUT_WIDTH.
    function automatic logic [63:0] sat_max(input int ow);
        return (64'd1 << (ow - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int ow);
        return 64'd1 << (ow - 1);
    endfunction

endpackage

// File: rtl/fixed_point_div_seq_if.sv
// rtl/fixed_point_div_seq_if.sv - operand/result handshake bundle for the sequential divider
interface fixed_point_div_seq_if
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] result;
    logic                 div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/fixed_point_div_step.sv
// rtl/fixed_point_div_step.sv - one combinational radix-2 restoring division step
module fixed_point_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH:0]   new_rem,
    output logic             q_bit
);
    localparam int RW = WIDTH + 1;

    logic [RW:0] shifted;
    logic [RW:0] dext;

    assign shifted = {rem, next_bit};
    assign dext    = {2'b00, divisor};
    assign q_bit   = (shifted >= dext);
    assign new_rem = q_bit ? RW'(shifted - dext) : RW'(shifted);

endmodule

// File: rtl/fixed_point_div_seq.sv
// rtl/fixed_point_div_seq.sv - multi-cycle signed fixed-point divider with divide-by-zero saturation
module fixed_point_div_seq
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC      = DEF_FRAC,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fixed_point_div_seq_if.slave  bus
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_SIGN = SIGN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

    generate
        if (OUT_WIDTH < WIDTH + FRAC + 1 || OUT_WIDTH > 64) begin : g_bad_width
            $error("fixed_point_div_seq: OUT_WIDTH must lie in [WIDTH+FRAC+1, 64]");
        end
    endgenerate

    logic [1:0]           state;
    logic                 neg;
    logic [WIDTH-1:0]     divisor;
    logic [N-1:0]         dividend;
    logic [WIDTH:0]       rem;
    logic [N-1:0]         quot;
    logic [CW-1:0]        count;
    logic [OUT_WIDTH-1:0] result_r;
    logic                 dbz_r;

    logic [WIDTH:0]       step_rem;
    logic                 step_q;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [OUT_WIDTH-1:0] qext;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    assign abs_a = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign abs_b = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    assign qext  = OUT_WIDTH'(quot);

    assign bus.in_ready    = (state == ST_IDLE);
    assign bus.out_valid   = (state == ST_DONE);
    assign bus.result      = result_r;
    assign bus.div_by_zero = dbz_r;

    fixed_point_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (divisor),
        .next_bit (dividend[N-1]),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            neg      <= 1'b0;
            divisor  <= '0;
            dividend <= '0;
            rem      <= '0;
            quot     <= '0;
            count    <= '0;
            result_r <= '0;
            dbz_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        neg      <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        divisor  <= abs_b;
                        dividend <= {abs_a, {FRAC{1'b0}}};
                        rem      <= '0;
                        quot     <= '0;
                        if (bus.b == '0) begin
                            dbz_r <= 1'b1;
                            if (bus.a == '0)
                                result_r <= '0;
                            else if (bus.a[WIDTH-1])
                                result_r <= SAT_MIN;
                            else
                                result_r <= SAT_MAX;
                            state <= ST_DONE;
                        end else begin
                            count <= CW'(N);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem      <= step_rem;
                    quot     <= {quot[N-2:0], step_q};
                    dividend <= {dividend[N-2:0], 1'b0};
                    count    <= count - 1'b1;
                    if (count == CW'(1))
                        state <= ST_SIGN;
                end
                ST_SIGN: begin
                    result_r <= neg ? (~qext + 1'b1) : qext;
                    dbz_r    <= 1'b0;
                    state    <= ST_DONE;
                end
                default: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_div_seq.sv
// tb/tb_fixed_point_div_seq.sv - directed, corner-case and randomised checks for fixed_point_div_seq
module tb_fixed_point_div_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    fixed_point_div_seq_if #(.WIDTH(16), .OUT_WIDTH(32)) bus ();

    fixed_point_div_seq #(.WIDTH(16), .FRAC(6), .OUT_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        int                 res;
        logic               dbz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic signed [15:0] ta, input logic signed [15:0] tb,
                          input logic [31:0] exp, input logic exp_dbz, input string tag);
        int lat;
        bus.a        = ta;
        bus.b        = tb;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'h5A5A;
        bus.b        = 16'h0000;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), exp_dbz ? 32'd1 : 32'd24);
        check({tag, " result"}, bus.result, exp);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        int seen;
        logic [31:0] held;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{16'sd64,     16'sd128,   32,        1'b0};
        vecs[1]  = '{16'sd64,     -16'sd128,  -32,       1'b0};
        vecs[2]  = '{-16'sd64,    -16'sd128,  32,        1'b0};
        vecs[3]  = '{16'sd32,     16'sd32,    64,        1'b0};
        vecs[4]  = '{16'sd6465,   16'sd482,   858,       1'b0};
        vecs[5]  = '{-16'sd6465,  16'sd482,   -858,      1'b0};
        vecs[6]  = '{-16'sd32768, 16'sd64,    -32768,    1'b0};
        vecs[7]  = '{-16'sd32768, 16'sd1,     -2097152,  1'b0};
        vecs[8]  = '{16'sd32767,  -16'sd1,    -2097088,  1'b0};
        vecs[9]  = '{16'sd64,     16'sd0,     32'h7FFFFFFF, 1'b1};
        vecs[10] = '{-16'sd64,    16'sd0,     32'h80000000, 1'b1};
        vecs[11] = '{16'sd0,      16'sd0,     0,         1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, 32'(vecs[i].res), vecs[i].dbz, $sformatf("vec%0d", i));

        // Backpressure: result held, in_ready low, queued in_valid accepted only after release.
        bus.out_ready = 1'b0;
        bus.a         = 16'sd6465;
        bus.b         = 16'sd482;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 16'sd64;
        bus.b = 16'sd128;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 32'(lat), 32'd24);
        held = bus.result;
        check("bp result", held, 32'd858);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp hold result %0d", i), bus.result, 32'd858);
            check($sformatf("bp hold out_valid %0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp hold in_ready %0d", i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp in_ready after release", 32'(bus.in_ready), 32'd1);
        check("bp out_valid after release", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp queued latency", 32'(lat), 32'd24);
        check("bp queued result", bus.result, 32'd32);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of CALC discards the operation.
        bus.a        = 16'sd64;
        bus.b        = 16'sd128;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort result", bus.result, 32'd0);
        check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort no out_valid", 32'(seen), 32'd0);
        run_op(16'sd64, 16'sd128, 32'd32, 1'b0, "after abort");

        // Randomised operands against a truncating behavioural model.
        for (int i = 0; i < 1000; i++) begin
            logic signed [15:0] ra;
            logic signed [15:0] rb;
            longint q;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rb == 0) rb = 16'sd1;
            q = (longint'(ra) * 64) / longint'(rb);
            run_op(ra, rb, 32'(q), 1'b0, $sformatf("rand %0d/%0d", ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
